// File: rtl/pc_update.sv
// -----------------------------------------------------------------------------
// pc_update
//
// Program-counter register and branch-redirect unit. A resolving branch is
// checked for "taken", its target is computed (register, imm26 or imm19
// relative), and the fetch PC is redirected. Every redirect raises a one-cycle
// flush to squash wrong-path fetches. A taken branch that resolves while fetch
// is stalled is parked in a pending register and applied when the stall drops.
//
// Ports
//   clk              : clock, all state changes on the rising edge
//   reset            : synchronous, active-low reset
//   stall            : hazard hold, PC must not advance
//   br_valid         : a branch resolves this cycle
//   UncondBr         : B (imm26 offset)
//   BrReg            : BR (target from register)
//   BranchCond       : resolved condition for CBZ / B.cond
//   br_pc            : PC of the resolving branch
//   imm19            : signed word offset for CBZ / B.cond
//   imm26            : signed word offset for B
//   reg_target       : register value for BR
//   pc               : current fetch address (registered)
//   flush            : one-cycle squash pulse (registered)
//   redirect_pending : high while a stalled redirect is parked (registered)
// -----------------------------------------------------------------------------
module pc_update #(
    parameter int              ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_valid,
    input  logic              UncondBr,
    input  logic              BrReg,
    input  logic              BranchCond,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [18:0]       imm19,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic              flush,
    output logic              redirect_pending
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              flush_q, flush_d;

    logic              taken;
    logic [ADDR_W-1:0] off19_ext;
    logic [ADDR_W-1:0] off26_ext;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] target;

    // Branch resolution and target: purely combinational.
    assign taken     = br_valid & (UncondBr | BrReg | BranchCond);
    assign off19_ext = {{(ADDR_W-19){imm19[18]}}, imm19};
    assign off26_ext = {{(ADDR_W-26){imm26[25]}}, imm26};
    assign br_off    = UncondBr ? off26_ext : off19_ext;

    // BrReg overrides UncondBr; offsets are in words, arithmetic wraps.
    assign target = BrReg ? reg_target : (br_pc + (br_off << 2));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        flush_d       = 1'b0;

        case (state_q)
            PENDING: begin
                // br_valid here comes from a wrong-path instruction: ignore it.
                if (!stall) begin
                    pc_d    = pend_target_q;
                    flush_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                if (taken && !stall) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                end else if (taken) begin
                    // Squash now, load the PC once the stall releases.
                    pend_target_d = target;
                    flush_d       = 1'b1;
                    state_d       = PENDING;
                end else if (!stall) begin
                    pc_d = pc_q + ADDR_W'(4);
                end
            end
        endcase
    end

    // Registered state and outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            flush_q       <= flush_d;
        end
    end

    assign pc               = pc_q;
    assign flush            = flush_q;
    assign redirect_pending = (state_q == PENDING);

endmodule

// File: tb/tb_pc_update.sv
module tb_pc_update;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic        UncondBr;
    logic        BrReg;
    logic        BranchCond;
    logic [63:0] br_pc;
    logic [18:0] imm19;
    logic [25:0] imm26;
    logic [63:0] reg_target;
    logic [63:0] pc;
    logic        flush;
    logic        redirect_pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] m_pc   = 64'h0;
    logic        m_fl   = 1'b0;
    logic        m_pend = 1'b0;
    logic [63:0] m_pt   = 64'h0;

    pc_update #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
        .UncondBr(UncondBr), .BrReg(BrReg), .BranchCond(BranchCond),
        .br_pc(br_pc), .imm19(imm19), .imm26(imm26), .reg_target(reg_target),
        .pc(pc), .flush(flush), .redirect_pending(redirect_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word offsets turned into plain integers, then scaled to bytes.
    function automatic longint s19(input logic [18:0] v);
        longint r = longint'(v);
        if (v[18]) r = r - (longint'(1) << 19);
        return r;
    endfunction

    function automatic longint s26(input logic [25:0] v);
        longint r = longint'(v);
        if (v[25]) r = r - (longint'(1) << 26);
        return r;
    endfunction

    task automatic model_step();
        logic        tk;
        logic [63:0] tgt;
        longint      off;
        if (!reset) begin
            m_pc = 64'h0; m_fl = 1'b0; m_pend = 1'b0; m_pt = 64'h0;
        end else if (m_pend) begin
            if (!stall) begin
                m_pc = m_pt; m_fl = 1'b1; m_pend = 1'b0;
            end else begin
                m_fl = 1'b0;
            end
        end else begin
            tk  = br_valid && (UncondBr || BrReg || BranchCond);
            off = UncondBr ? s26(imm26) : s19(imm19);
            tgt = BrReg ? reg_target : br_pc + 64'(off * 4);
            if (tk && !stall) begin
                m_pc = tgt; m_fl = 1'b1;
            end else if (tk) begin
                m_pt = tgt; m_pend = 1'b1; m_fl = 1'b1;
            end else if (stall) begin
                m_fl = 1'b0;
            end else begin
                m_pc = m_pc + 64'd4; m_fl = 1'b0;
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, ".pc"},    pc,                       m_pc);
        check({tag, ".flush"}, 64'(flush),               64'(m_fl));
        check({tag, ".pend"},  64'(redirect_pending),    64'(m_pend));
    endtask

    task automatic idle_inputs();
        stall = 0; br_valid = 0; UncondBr = 0; BrReg = 0; BranchCond = 0;
        br_pc = 64'h0; imm19 = '0; imm26 = '0; reg_target = 64'h0;
    endtask

    task automatic set_cbz(input logic [63:0] bpc, input logic [18:0] imm, input logic cond);
        br_valid = 1; BranchCond = cond; UncondBr = 0; BrReg = 0;
        br_pc = bpc; imm19 = imm;
    endtask

    initial begin
        idle_inputs();
        reset = 0;

        // Reset, then sequential run
        cycle("rst0");
        cycle("rst1");
        check("rst_pc_const", pc, 64'h0);
        check("rst_pend_const", 64'(redirect_pending), 64'h0);
        reset = 1;
        cycle("seq4");  check("seq_pc4", pc, 64'h4);
        cycle("seq8");  check("seq_pc8", pc, 64'h8);
        cycle("seq12"); check("seq_pc12", pc, 64'hC);

        // CBZ taken, backward offset -2 words
        set_cbz(64'h100, 19'h7FFFE, 1'b1);
        cycle("cbz");
        check("cbz_pc", pc, 64'hF8);
        check("cbz_flush", 64'(flush), 64'h1);
        idle_inputs();
        cycle("cbz_after");
        check("cbz_flush_drop", 64'(flush), 64'h0);
        check("cbz_seq", pc, 64'hFC);

        // CBZ not taken
        set_cbz(64'h100, 19'h7FFFE, 1'b0);
        cycle("cbz_nt");
        check("cbz_nt_pc", pc, 64'h100);
        check("cbz_nt_flush", 64'(flush), 64'h0);

        // B with wrap-around
        idle_inputs();
        br_valid = 1; UncondBr = 1; br_pc = 64'hFFFF_FFFF_FFFF_FFFC; imm26 = 26'd2;
        cycle("bwrap");
        check("bwrap_pc", pc, 64'h4);

        // BR beats B
        idle_inputs();
        br_valid = 1; UncondBr = 1; BrReg = 1; reg_target = 64'h2000; imm26 = 26'd100;
        cycle("brprio");
        check("brprio_pc", pc, 64'h2000);

        // Back-to-back taken branches keep flush high
        idle_inputs();
        set_cbz(64'h500, 19'd8, 1'b1);
        cycle("b2b0");
        set_cbz(64'h600, 19'd4, 1'b1);
        cycle("b2b1");
        check("b2b_pc", pc, 64'h610);
        check("b2b_flush", 64'(flush), 64'h1);
        idle_inputs();
        cycle("b2b_end");

        // Stalled redirect: branch in first stall cycle, target 0x400
        begin
            logic [63:0] held;
            held = pc;
            stall = 1; set_cbz(64'h300, 19'h40, 1'b1);
            cycle("stl0");
            check("stl0_flush", 64'(flush), 64'h1);
            check("stl0_pend", 64'(redirect_pending), 64'h1);
            check("stl0_hold", pc, held);
            // Wrong-path branch while pending is ignored
            br_valid = 1; BranchCond = 0; UncondBr = 1; imm26 = 26'd64; br_pc = 64'h800;
            cycle("stl1");
            check("stl1_flush", 64'(flush), 64'h0);
            idle_inputs(); stall = 1;
            cycle("stl2");
            check("stl2_hold", pc, held);
            stall = 0;
            cycle("stl_rel");
            check("stl_rel_pc", pc, 64'h400);
            check("stl_rel_flush", 64'(flush), 64'h1);
            check("stl_rel_pend", 64'(redirect_pending), 64'h0);
            cycle("stl_post");
            check("stl_post_pc", pc, 64'h404);
        end

        // Reset during PENDING discards the parked target
        stall = 1; set_cbz(64'h300, 19'h40, 1'b1);
        cycle("rp0");
        check("rp_pend", 64'(redirect_pending), 64'h1);
        idle_inputs(); stall = 1; reset = 0;
        cycle("rp_rst");
        check("rp_rst_pc", pc, 64'h0);
        check("rp_rst_pend", 64'(redirect_pending), 64'h0);
        reset = 1; stall = 0;
        cycle("rp_run");
        check("rp_run_pc", pc, 64'h4);
        for (int i = 0; i < 4; i++) begin
            cycle("rp_seq");
            check("rp_never400", 64'(pc == 64'h400), 64'h0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 63) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            br_valid   = ($urandom_range(0, 2) == 0);
            UncondBr   = ($urandom_range(0, 3) == 0);
            BrReg      = ($urandom_range(0, 4) == 0);
            BranchCond = $urandom_range(0, 1);
            br_pc      = {$urandom, $urandom};
            imm19      = 19'($urandom);
            imm26      = 26'($urandom);
            reg_target = {$urandom, $urandom};
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_update.md
# pc_update

Program-counter register and branch-redirect unit for the pipelined ARM64 core. It consumes the resolved `BranchCond` from the branch condition checker together with the branch-type controls, computes the branch target, and loads the next fetch address. It emits a one-cycle `flush` to squash wrong-path fetches. A taken branch that resolves during a fetch stall is held in a pending register and applied when the stall releases.

## Interface
- `ADDR_W`, 64, PC and target width
- `RESET_PC`, 64'h0, PC value loaded at reset
- `clk` in 1: single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-low (0 = reset), sampled on the rising edge of `clk`
- `stall` in 1: hazard unit hold; PC must not advance
- `br_valid` in 1: a branch instruction resolves this cycle
- `UncondBr` in 1: B (unconditional, imm26)
- `BrReg` in 1: BR (target taken from register)
- `BranchCond` in 1: from the branch condition checker (CBZ / B.LT taken)
- `br_pc` in ADDR_W: PC of the resolving branch
- `imm19` in 19: CBZ / B.cond offset, in words, signed
- `imm26` in 26: B offset, in words, signed
- `reg_target` in ADDR_W: BR target register value
- `pc` out ADDR_W: current fetch address
- `flush` out 1: squash IF/ID contents; one-cycle pulse
- `redirect_pending` out 1: high while in the PENDING state

## Operation
- `taken = br_valid & (UncondBr | BrReg | BranchCond)`.
- Target selection, evaluated in this order:
  - `BrReg`: `reg_target` verbatim.
  - `UncondBr`: `br_pc + (sext(imm26) << 2)`.
  - Otherwise: `br_pc + (sext(imm19) << 2)`.
- All target arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- If more than one of `UncondBr` and `BrReg` is set, `BrReg` wins.
- FSM states:
  - IDLE (reset state).
  - PENDING: holds `pend_target`, a register of width ADDR_W.
- Next-state and PC update, in priority order:
  1. `reset` == 0 → `pc` = RESET_PC, `flush` = 0, IDLE, `pend_target` = 0.
  2. PENDING & !`stall` → `pc` = `pend_target`, `flush` = 1, IDLE.
  3. PENDING & `stall` → hold all state, `flush` = 0.
  4. IDLE & `taken` & !`stall` → `pc` = target, `flush` = 1.
  5. IDLE & `taken` & `stall` → `pend_target` = target, PENDING, `pc` held, `flush` = 1 (squash immediately).
  6. IDLE & `stall` → `pc` held, `flush` = 0.
  7. Otherwise → `pc` = `pc` + 4, `flush` = 0.
- `br_valid` in PENDING is ignored, because it comes from a wrong-path instruction.
- Not-taken branches (`br_valid` & !`taken`) behave as sequential execution.

## Timing
- `flush`, `pc` and `redirect_pending` are registered outputs. `taken` and target are combinational.
- Redirect latency: a taken branch sampled at edge N gives `pc` = target after edge N. `flush` is high for the cycle following edge N only.
- Stalled redirect: `flush` rises after the edge where the branch is sampled. A second `flush` pulse follows the edge where the stall releases and `pc` loads `pend_target`.
- `redirect_pending` equals (state == PENDING) and is 0 out of reset.
- Reset values: `pc` = RESET_PC, `flush` = 0, `redirect_pending` = 0.
- Reset asserted mid-PENDING discards `pend_target` at that edge.
- Back-to-back taken branches in consecutive cycles (IDLE, no stall) each redirect. `flush` stays high across both cycles.

## Test plan
- Reset then run: hold `reset`=0 for 2 cycles, release with no branches → `pc` goes 0, 4, 8, 12 and `flush` stays 0.
- CBZ taken: `br_pc`=0x100, `imm19`=0x7FFFE (−2), `BranchCond`=1, `br_valid`=1 for one cycle → next `pc`=0xF8 and `flush` is a 1-cycle pulse. With `BranchCond`=0 → `pc`=previous+4 and no flush.
- B wrap: `br_pc`=0xFFFF_FFFF_FFFF_FFFC, `imm26`=2, `UncondBr`=1 → `pc`=0x4.
- BR priority: `BrReg`=1, `UncondBr`=1, `reg_target`=0x2000 → `pc`=0x2000.
- Stalled redirect:
  - Stimulus: `stall`=1 for 3 cycles, with a taken branch (target 0x400) in the first stall cycle.
  - Required: `flush` pulses once, `redirect_pending`=1 and `pc` is held for the stall cycles.
  - On stall release: `pc`=0x400, second `flush` pulse, `redirect_pending`=0.
  - A `br_valid` pulse asserted during PENDING is ignored.
- Reset during PENDING: set up as above, then `reset`=0 while `redirect_pending`=1 → `pc`=RESET_PC and `redirect_pending`=0. After release, `pc` goes RESET_PC+4 and never reaches 0x400.
